burst_checker: RTL and testbench
================================

# burst_checker

Receive-side checker for the ADC test-pattern burst stream: a `dv` qualifier plus 8-bit data, incrementing from a start value for `COUNT_LENGTH+1` words, with the data parked at an idle value between bursts. It sits on the clustering_db input path, downstream of the pattern generator, during bring-up and self-test. It verifies:

- the sequence of each burst;
- the length of each burst;
- the idle value between bursts.

It reports per-burst results and sticky status to the slow-control readout.

## Interface
- `COUNT_LENGTH`, default 47: nominal burst is `COUNT_LENGTH+1` = 48 words; legal range 0..254.
- `IDLE_VALUE`, default 200: data value required while `dv`=0 between bursts.
- `clk` in, 1 bit: single clock; all logic on posedge.
- `rst` in, 1 bit: reset, asynchronous, active-low.
- `dv` in, 1 bit: data valid from the stream source.
- `din` in, 8 bits: stream data.
- `clr` in, 1 bit: synchronous clear of status and counters; forces IDLE.
- `busy` out, 1 bit: high while in RECV.
- `done` out, 1 bit: one-cycle pulse at the end of each burst.
- `first_val` out, 8 bits: first word of the last burst (the start value).
- `burst_len` out, 8 bits: word count of the last completed burst.
- `seq_err` out, 1 bit: sticky flag; any word differed from its expected value.
- `len_err` out, 1 bit: sticky flag; any burst length differed from `COUNT_LENGTH+1`.
- `idle_err` out, 1 bit: sticky flag; `din` differed from `IDLE_VALUE` during a gap.
- `err_cnt` out, 8 bits: total mismatched words; saturates at 255.
- `burst_cnt` out, 16 bits: completed bursts; wraps at 65535 to 0.

## Operation
- **States.** The FSM has three states: IDLE, RECV and GAP.
- **Reset.** Reset (`rst`=0) forces IDLE and sets every output and internal register to 0.
- **Precedence of `clr`.** `clr`=1 at an edge has the same effect as reset (synchronous). It has priority over `dv` at that edge.
- **IDLE.**
  - With `dv`=0: no checks. `din` is ignored, because the source data is undefined after reset.
  - With `dv`=1: load `first_val`<=`din`, `exp`<=`din`+1 (mod 256) and `cnt`<=1; go to RECV.
- **RECV, `dv`=1.**
  - Compare `din` with `exp`.
  - On mismatch: `seq_err`<=1 and `err_cnt`<=min(`err_cnt`+1, 255).
  - `exp` always advances from the expected value (`exp`+1 mod 256), not from `din`, so a single bad word counts once.
  - `cnt`<=min(`cnt`+1, 255).
- **RECV, `dv`=0 (burst end).**
  - `burst_len`<=`cnt`.
  - `len_err`<=1 if `cnt`!=`COUNT_LENGTH+1`.
  - `burst_cnt`+=1 and `done`<=1.
  - Check `din` against `IDLE_VALUE` in this same cycle: mismatch sets `idle_err`.
  - Go to GAP.
- **GAP, `dv`=0.** Each cycle, `din`!=`IDLE_VALUE` sets `idle_err`.
- **GAP, `dv`=1.** Start a new burst exactly as from IDLE.
- **Arithmetic.** All data arithmetic is 8-bit modulo 256. A burst that starts at 250 expects 251, 252 … 255, 0, 1 … with no error at the wrap.
- **Minimum burst.** A single-cycle `dv` pulse gives `burst_len`=1. `len_err` is set unless `COUNT_LENGTH`=0.
- **Burst boundaries.** A burst is ended only by `dv`=0. Back-to-back bursts with no gap cycle are indistinguishable from one long burst, which then flags `len_err` and/or `seq_err`.

## Timing
- Every output is registered; there is no combinational path from input to output.
- **`done`:** high for exactly the one cycle after the edge that samples the first `dv`=0 in RECV.
- **Per-burst results:** `burst_len`, `burst_cnt` and `len_err` update on that same edge, so they are valid while `done`=1.
- **`seq_err` and `err_cnt`:** update on the edge that samples the bad word (1-cycle latency).
- **`first_val`:** valid from the cycle after the first `dv`=1 edge. It holds until the next burst starts.
- **`busy`:** =1 from the cycle after the first `dv`=1 edge until the cycle after the terminating `dv`=0 edge.
- **Throughput:** one word per clock, no backpressure, so `dv` may be high every cycle.
- **Nominal source period:** 256 cycles, made of 48 `dv`=1 cycles followed by 208 idle cycles.
- **Reset mid-burst:** all results are discarded; no `done` is produced for the partial burst.
- **`clr` mid-burst:** same effect as reset mid-burst. The first `dv`=1 after `clr` starts a fresh burst.

## Test plan
- **Nominal burst.** Reset, then a 48-word burst starting at 5 (5..52), then 208 cycles of `din`=200 with `dv`=0.
  - `done` pulses once.
  - `burst_len`=48, `first_val`=5, `burst_cnt`=1.
  - All error flags 0 and `err_cnt`=0.
- **Wrap-around.** A 48-word burst starting at 230 (…255, 0 … 21).
  - No `seq_err`.
  - `burst_len`=48.
- **Corrupted words.** In a nominal burst starting at 0, word 10 carries 99 instead of 10 and word 20 carries 0 instead of 20.
  - `seq_err`=1, `err_cnt`=2, `len_err`=0.
- **Length errors.**
  - A 40-word burst: `burst_len`=40, `len_err`=1.
  - A 300-word burst: `burst_len`=255, `len_err`=1.
- **Idle violation.** Nominal burst followed by `din`=199 for one gap cycle.
  - `idle_err`=1.
  - `clr` for one cycle then returns all flags, `err_cnt` and `burst_cnt` to 0.
- **Mid-burst `rst` and simultaneous `clr`.**
  - `rst` after word 20: no `done`; after release, a fresh nominal burst gives `burst_cnt`=1.
  - `clr`=1 on the same edge as the first `dv`=1: that word is ignored; a burst starts on the next `dv`=1.

Source files
------------

// File: rtl/burst_checker.sv
// Receive-side checker for the ADC test-pattern burst stream: verifies the
// incrementing sequence, the burst length and the idle value between bursts.
module burst_checker #(
  parameter int unsigned COUNT_LENGTH = 47,
  parameter int unsigned IDLE_VALUE   = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dv,
  input  logic [7:0]  din,
  input  logic        clr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  first_val,
  output logic [7:0]  burst_len,
  output logic        seq_err,
  output logic        len_err,
  output logic        idle_err,
  output logic [7:0]  err_cnt,
  output logic [15:0] burst_cnt
);

  localparam logic [7:0] NOM_LEN   = 8'(COUNT_LENGTH + 1);
  localparam logic [7:0] IDLE_DATA = 8'(IDLE_VALUE);

  typedef enum logic [1:0] {IDLE, RECV, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] exp_data;
  logic [7:0] cnt;
  logic       start, word, last, idle_chk;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    word      = 1'b0;
    last      = 1'b0;
    idle_chk  = 1'b0;
    case (state)
      IDLE: begin
        if (dv) begin
          start     = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (dv) begin
          word = 1'b1;
        end else begin
          last      = 1'b1;
          idle_chk  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (dv) begin
          start     = 1'b1;
          state_nxt = RECV;
        end else begin
          idle_chk = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // busy decodes the state register directly, so it stays a registered output.
  assign busy = (state == RECV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done      <= 1'b0;
      first_val <= '0;
      burst_len <= '0;
      seq_err   <= 1'b0;
      len_err   <= 1'b0;
      idle_err  <= 1'b0;
      err_cnt   <= '0;
      burst_cnt <= '0;
      exp_data  <= '0;
      cnt       <= '0;
    end else if (clr) begin
      done      <= 1'b0;
      first_val <= '0;
      burst_len <= '0;
      seq_err   <= 1'b0;
      len_err   <= 1'b0;
      idle_err  <= 1'b0;
      err_cnt   <= '0;
      burst_cnt <= '0;
      exp_data  <= '0;
      cnt       <= '0;
    end else begin
      done <= last;
      if (start) begin
        first_val <= din;
        exp_data  <= din + 8'd1;
        cnt       <= 8'd1;
      end
      // exp_data advances from itself, not from din, so one bad word counts once.
      if (word) begin
        if (din != exp_data) begin
          seq_err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        exp_data <= exp_data + 8'd1;
        if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      end
      if (last) begin
        burst_len <= cnt;
        if (cnt != NOM_LEN) len_err <= 1'b1;
        burst_cnt <= burst_cnt + 16'd1;
      end
      if (idle_chk && (din != IDLE_DATA)) idle_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_burst_checker.sv
// Scoreboard bench for burst_checker: expected per-burst results are queued as
// bursts are driven and compared when done pulses.
module tb_burst_checker;

  localparam logic [7:0] IDLE_V = 8'd200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dv  = 1'b0;
  logic [7:0]  din = '0;
  logic        clr = 1'b0;
  logic        busy, done, seq_err, len_err, idle_err;
  logic [7:0]  first_val, burst_len, err_cnt;
  logic [15:0] burst_cnt;

  burst_checker #(.COUNT_LENGTH(47), .IDLE_VALUE(200)) dut (
    .clk(clk), .rst(rst), .dv(dv), .din(din), .clr(clr),
    .busy(busy), .done(done), .first_val(first_val), .burst_len(burst_len),
    .seq_err(seq_err), .len_err(len_err), .idle_err(idle_err),
    .err_cnt(err_cnt), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  len;
    logic [7:0]  first;
    logic [15:0] bcnt;
    logic        len_err;
    logic        seq_err;
    logic [7:0]  err_cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model of the sticky status
  logic        m_seq, m_len, m_idle, m_gap;
  logic [7:0]  m_err;
  logic [15:0] m_bcnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_seq = 0; m_len = 0; m_idle = 0; m_gap = 0; m_err = '0; m_bcnt = '0;
  endtask

  task automatic send_burst(input logic [7:0] start, input int unsigned n,
                            input int bi0, input logic [7:0] bv0,
                            input int bi1, input logic [7:0] bv1, input bit push);
    logic [7:0] nom, w, cnt;
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      nom = start + 8'(i);
      w = nom;
      if (int'(i) == bi0) w = bv0;
      if (int'(i) == bi1) w = bv1;
      @(negedge clk);
      if (i == 1) check("busy_in_burst", busy, 1);
      dv = 1'b1;
      din = w;
      if (i > 0 && w != nom) begin
        m_seq = 1;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
    end
    if (push) begin
      cnt = (n > 255) ? 8'd255 : 8'(n);
      m_bcnt = m_bcnt + 16'd1;
      if (cnt != 8'd48) m_len = 1;
      m_gap = 1;
      e.len = cnt; e.first = start; e.bcnt = m_bcnt;
      e.len_err = m_len; e.seq_err = m_seq; e.err_cnt = m_err;
      q.push_back(e);
    end
  endtask

  task automatic gap(input int unsigned n, input logic [7:0] val);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      dv = 1'b0;
      din = val;
      if (m_gap && val != IDLE_V) m_idle = 1;
    end
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".seq_err"}, seq_err, m_seq);
    check({tag, ".len_err"}, len_err, m_len);
    check({tag, ".idle_err"}, idle_err, m_idle);
    check({tag, ".err_cnt"}, err_cnt, m_err);
    check({tag, ".burst_cnt"}, burst_cnt, m_bcnt);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1; dv = 1'b0; din = IDLE_V;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  // done monitor: every pulse must match the oldest queued burst
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = q.pop_front();
          check("burst_len", burst_len, e.len);
          check("first_val", first_val, e.first);
          check("done_burst_cnt", burst_cnt, e.bcnt);
          check("done_len_err", len_err, e.len_err);
          check("done_seq_err", seq_err, e.seq_err);
          check("done_err_cnt", err_cnt, e.err_cnt);
        end
      end
    end
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.first_val", first_val, 0);
    check("rst.burst_len", burst_len, 0);
    check_status("rst");
    rst = 1'b1;

    // IDLE after reset ignores din
    gap(4, 8'd0);
    check_status("idle_ignore");

    // nominal burst 5..52
    send_burst(8'd5, 48, -1, 0, -1, 0, 1);
    gap(208, IDLE_V);
    check_status("nominal");

    // wrap-around 230..21
    send_burst(8'd230, 48, -1, 0, -1, 0, 1);
    gap(20, IDLE_V);
    check_status("wrap");

    // two corrupted words
    send_burst(8'd0, 48, 10, 8'd99, 20, 8'd0, 1);
    gap(20, IDLE_V);
    check_status("corrupt");
    clr_pulse();
    check_status("clr1");

    // length errors: short, saturating long, single word
    send_burst(8'd17, 40, -1, 0, -1, 0, 1);
    gap(10, IDLE_V);
    check_status("len40");
    send_burst(8'd0, 300, -1, 0, -1, 0, 1);
    gap(10, IDLE_V);
    check_status("len300");
    send_burst(8'd9, 1, -1, 0, -1, 0, 1);
    gap(10, IDLE_V);
    check_status("len1");
    clr_pulse();

    // idle violation for one gap cycle, then clear
    send_burst(8'd3, 48, -1, 0, -1, 0, 1);
    gap(2, IDLE_V);
    gap(1, 8'd199);
    gap(5, IDLE_V);
    check_status("idle_viol");
    clr_pulse();
    check_status("clr2");

    // reset after word 20 discards the partial burst
    send_burst(8'd0, 21, -1, 0, -1, 0, 0);
    @(negedge clk);
    rst = 1'b0; dv = 1'b0; din = IDLE_V;
    model_clear();
    @(negedge clk);
    check("midrst.done", done, 0);
    check("midrst.busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    gap(3, IDLE_V);
    send_burst(8'd40, 48, -1, 0, -1, 0, 1);
    gap(10, IDLE_V);
    check_status("after_rst");

    // clr on the same edge as the first dv=1 drops that word
    @(negedge clk);
    clr = 1'b1; dv = 1'b1; din = 8'd77;
    @(negedge clk);
    clr = 1'b0; dv = 1'b0; din = IDLE_V;
    model_clear();
    gap(3, IDLE_V);
    check_status("clr_dv");
    send_burst(8'd10, 48, -1, 0, -1, 0, 1);
    gap(10, IDLE_V);
    check_status("after_clr_dv");

    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
